// File: rtl/tlc_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlc_phase_arbiter
// Description : Demand-actuated phase scheduler for one intersection.
//               Shares right-of-way between the north-south and east-west
//               approaches with min/max green, yellow and all-red clearance.
//               Optional pedestrian phase after AR2 when the macro
//               TLC_PED_EN is defined; without it ped_req is ignored and
//               walk stays low.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc_phase_arbiter #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 3000,
    parameter int YELLOW_TIME = 500,
    parameter int ALLRED_TIME = 100,
    parameter int PED_TIME    = 800,
    parameter int CWIDTH      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic       NS_Red,
    output logic       NS_Yellow,
    output logic       NS_Green,
    output logic       EW_Red,
    output logic       EW_Yellow,
    output logic       EW_Green,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR2  = 3'd5,
        PED  = 3'd6
    } state_t;

    // Terminal counter values: a timed state lasts N cycles when it exits at N-1.
    localparam logic [CWIDTH-1:0] MIN_LAST    = CWIDTH'(MIN_GREEN - 1);
    localparam logic [CWIDTH-1:0] MAX_LAST    = CWIDTH'(MAX_GREEN - 1);
    localparam logic [CWIDTH-1:0] YELLOW_LAST = CWIDTH'(YELLOW_TIME - 1);
    localparam logic [CWIDTH-1:0] ALLRED_LAST = CWIDTH'(ALLRED_TIME - 1);
    localparam logic [CWIDTH-1:0] PED_LAST    = CWIDTH'(PED_TIME - 1);

    state_t            state;
    state_t            next_state;
    logic [CWIDTH-1:0] cnt;
    logic              ns_dem;
    logic              ew_dem;
    logic              ped_go;

`ifdef TLC_PED_EN
    logic              ped_dem;

    // Pedestrian latch: set by the button, cleared on entering PED (clear wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_dem <= 1'b0;
        end else if (next_state == PED && state != PED) begin
            ped_dem <= 1'b0;
        end else if (ped_req) begin
            ped_dem <= 1'b1;
        end
    end

    assign ped_go = ped_dem;
    assign walk   = (state == PED);
`else
    // Button input has no function in this build.
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_go         = 1'b0;
    assign walk           = 1'b0;
`endif

    // Next-state selection; greens leave only when the opposing approach waits.
    always_comb begin
        next_state = NS_G;
        case (state)
            NS_G: begin
                next_state = NS_G;
                if (ew_dem && ((cnt >= MIN_LAST && !ns_req) || cnt >= MAX_LAST))
                    next_state = NS_Y;
            end
            NS_Y: next_state = (cnt == YELLOW_LAST) ? AR1 : NS_Y;
            AR1:  next_state = (cnt == ALLRED_LAST) ? EW_G : AR1;
            EW_G: begin
                next_state = EW_G;
                if (ns_dem && ((cnt >= MIN_LAST && !ew_req) || cnt >= MAX_LAST))
                    next_state = EW_Y;
            end
            EW_Y: next_state = (cnt == YELLOW_LAST) ? AR2 : EW_Y;
            AR2: begin
                next_state = AR2;
                if (cnt == ALLRED_LAST)
                    next_state = ped_go ? PED : NS_G;
            end
            PED:  next_state = (cnt == PED_LAST) ? NS_G : PED;
            default: next_state = NS_G;
        endcase
    end

    // State, phase counter and approach demand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= NS_G;
            cnt    <= '0;
            ns_dem <= 1'b0;
            ew_dem <= 1'b0;
        end else begin
            state <= next_state;

            if (next_state != state)
                cnt <= '0;
            else if ((state == NS_G || state == EW_G) && cnt >= MAX_LAST)
                cnt <= MAX_LAST;
            else
                cnt <= cnt + 1'b1;

            if (next_state == NS_G && state != NS_G)
                ns_dem <= 1'b0;
            else if (ns_req && state != NS_G)
                ns_dem <= 1'b1;

            if (next_state == EW_G && state != EW_G)
                ew_dem <= 1'b0;
            else if (ew_req && state != EW_G)
                ew_dem <= 1'b1;
        end
    end

    // Lamp decode straight from the state register; illegal codes show all-red.
    always_comb begin
        NS_Red    = 1'b0;
        NS_Yellow = 1'b0;
        NS_Green  = 1'b0;
        EW_Red    = 1'b0;
        EW_Yellow = 1'b0;
        EW_Green  = 1'b0;
        case (state)
            NS_G: begin NS_Green  = 1'b1; EW_Red = 1'b1; end
            NS_Y: begin NS_Yellow = 1'b1; EW_Red = 1'b1; end
            EW_G: begin EW_Green  = 1'b1; NS_Red = 1'b1; end
            EW_Y: begin EW_Yellow = 1'b1; NS_Red = 1'b1; end
            default: begin NS_Red = 1'b1; EW_Red = 1'b1; end
        endcase
    end

    assign phase = state;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlc_phase_arbiter
// Description : Directed self-checking bench for tlc_phase_arbiter with
//               MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2, ALLRED_TIME=1,
//               PED_TIME=3. Edge numbers count rising edges after reset
//               release, starting at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlc_phase_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       NS_Red, NS_Yellow, NS_Green;
    logic       EW_Red, EW_Yellow, EW_Green;
    logic       walk;
    logic [2:0] phase;

    int n_cmp  = 0;
    int n_fail = 0;

    tlc_phase_arbiter #(
        .MIN_GREEN  (4),
        .MAX_GREEN  (8),
        .YELLOW_TIME(2),
        .ALLRED_TIME(1),
        .PED_TIME   (3),
        .CWIDTH     (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ns_req   (ns_req),
        .ew_req   (ew_req),
        .ped_req  (ped_req),
        .NS_Red   (NS_Red),
        .NS_Yellow(NS_Yellow),
        .NS_Green (NS_Green),
        .EW_Red   (EW_Red),
        .EW_Yellow(EW_Yellow),
        .EW_Green (EW_Green),
        .walk     (walk),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    // Expected {phase, NS_R, NS_Y, NS_G, EW_R, EW_Y, EW_G, walk} for a phase code.
    function automatic logic [9:0] exp_out(input int ph);
        logic [6:0] l;
        case (ph)
            0:       l = 7'b001_100_0;
            1:       l = 7'b010_100_0;
            2:       l = 7'b100_100_0;
            3:       l = 7'b100_001_0;
            4:       l = 7'b100_010_0;
            5:       l = 7'b100_100_0;
            6:       l = 7'b100_100_1;
            default: l = 7'b000_000_0;
        endcase
        return {3'(ph), l};
    endfunction

    function automatic logic [9:0] got_out();
        return {phase, NS_Red, NS_Yellow, NS_Green, EW_Red, EW_Yellow, EW_Green, walk};
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        ns_req  = 1'b0;
        ew_req  = 1'b0;
        ped_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] g;
        rst_n = 1'b0;
        #2;
        g = got_out();
        n_cmp++;
        if (g !== exp_out(0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", g, exp_out(0));
        end
    endtask

    task automatic test_idle_rest();
        logic [9:0] g;
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            tick();
            g = got_out();
            n_cmp++;
            if (g !== exp_out(0)) begin
                n_fail++;
                $display("FAIL idle_rest edge %0d: got %b want %b", e, g, exp_out(0));
            end
        end
    endtask

    task automatic test_gap_out();
        logic [9:0] g;
        int ep;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            ew_req = (e == 10);
            tick();
            ep = (e <= 10) ? 0 : (e <= 12) ? 1 : (e == 13) ? 2 : 3;
            g = got_out();
            n_cmp++;
            if (g !== exp_out(ep)) begin
                n_fail++;
                $display("FAIL gap_out edge %0d: got %b want %b", e, g, exp_out(ep));
            end
        end
        ew_req = 1'b0;
    endtask

    // Max-out of NS green, then gap-out of EW green; ns_req stays high into
    // the return to NS_G so the simultaneous set/clear must leave ns_dem low.
    task automatic test_max_out();
        logic [9:0] g;
        int ep;
        do_reset();
        ns_req = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            ew_req = (e == 1);
            ns_req = (e <= 18);
            tick();
            ep = (e <= 7)  ? 0 : (e <= 9)  ? 1 : (e == 10) ? 2 :
                 (e <= 14) ? 3 : (e <= 16) ? 4 : (e == 17) ? 5 : 0;
            g = got_out();
            n_cmp++;
            if (g !== exp_out(ep)) begin
                n_fail++;
                $display("FAIL max_out edge %0d: got %b want %b", e, g, exp_out(ep));
            end
        end
        ns_req = 1'b0;
        ew_req = 1'b0;
    endtask

    task automatic test_pedestrian();
        logic [9:0] g;
        int ep;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            ew_req  = (e == 1);
            ns_req  = (e == 8);
            ped_req = (e == 8);
            tick();
`ifdef TLC_PED_EN
            ep = (e <= 3)  ? 0 : (e <= 5)  ? 1 : (e == 6)  ? 2 :
                 (e <= 10) ? 3 : (e <= 12) ? 4 : (e == 13) ? 5 :
                 (e <= 16) ? 6 : 0;
`else
            ep = (e <= 3)  ? 0 : (e <= 5)  ? 1 : (e == 6)  ? 2 :
                 (e <= 10) ? 3 : (e <= 12) ? 4 : (e == 13) ? 5 : 0;
`endif
            g = got_out();
            n_cmp++;
            if (g !== exp_out(ep)) begin
                n_fail++;
                $display("FAIL pedestrian edge %0d: got %b want %b", e, g, exp_out(ep));
            end
        end
        ns_req  = 1'b0;
        ew_req  = 1'b0;
        ped_req = 1'b0;
    endtask

    // Reset asserted between edges during EW_Y with ew_dem freshly set; the
    // latch must be gone after release, so NS_G rests with no requests.
    task automatic test_async_reset();
        logic [9:0] g;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            ew_req = (e == 1) || (e == 12);
            ns_req = (e == 7);
            tick();
        end
        ew_req = 1'b0;
        ns_req = 1'b0;
        g = got_out();
        n_cmp++;
        if (g !== exp_out(4)) begin
            n_fail++;
            $display("FAIL async_pre_ew_y: got %b want %b", g, exp_out(4));
        end
        #2;
        rst_n = 1'b0;
        #1;
        g = got_out();
        n_cmp++;
        if (g !== exp_out(0)) begin
            n_fail++;
            $display("FAIL async_immediate: got %b want %b", g, exp_out(0));
        end
        tick();
        g = got_out();
        n_cmp++;
        if (g !== exp_out(0)) begin
            n_fail++;
            $display("FAIL async_held: got %b want %b", g, exp_out(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            g = got_out();
            n_cmp++;
            if (g !== exp_out(0)) begin
                n_fail++;
                $display("FAIL async_release edge %0d: got %b want %b", e, g, exp_out(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_rest();
        test_gap_out();
        test_max_out();
        test_pedestrian();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tlc_phase_arbiter.md
# tlc_phase_arbiter

Demand-actuated phase scheduler for one intersection. It arbitrates the single shared right-of-way between north-south and east-west approach requests, using the previously unused sensor inputs. It enforces minimum and maximum green, yellow and all-red clearance, and drives the six lamp signals. It sits in place of the fixed-time controller ahead of the per-lamp PWM stage, one instance per intersection.

## Interface
- `MIN_GREEN`, 4: minimum green duration in cycles, ≥1.
- `MAX_GREEN`, 3000: maximum green duration while the opposing approach is waiting. Must satisfy ≥ `MIN_GREEN`.
- `YELLOW_TIME`, 500: yellow duration in cycles, ≥1.
- `ALLRED_TIME`, 100: all-red clearance duration in cycles, ≥1.
- `PED_TIME`, 800: pedestrian walk duration in cycles, ≥1. Used only with `TLC_PED_EN`.
- `CWIDTH`, 16: phase counter width. Every time parameter must be ≤ 2^CWIDTH.
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ns_req` in 1: north-south demand (sensor level). Sampled every cycle.
- `ew_req` in 1: east-west demand (sensor level). Sampled every cycle.
- `ped_req` in 1: pedestrian button. Sampled every cycle.
- `NS_Red`, `NS_Yellow`, `NS_Green` out 1: north-south lamps.
- `EW_Red`, `EW_Yellow`, `EW_Green` out 1: east-west lamps.
- `walk` out 1: pedestrian walk lamp.
- `phase` out 3: current state encoding.

## Operation
- **States and `phase` codes:** NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5, PED=6. Codes 7 and unused map to NS_G on the next edge.
- **Lamps:**
  - NS_G: NS_Green + EW_Red.
  - NS_Y: NS_Yellow + EW_Red.
  - EW_G: EW_Green + NS_Red.
  - EW_Y: EW_Yellow + NS_Red.
  - AR1, AR2, PED: NS_Red + EW_Red.
  - walk=1 only in PED.
  - Exactly one lamp per approach is high at all times.
- **Counter:**
  - Clears to 0 on every state change; otherwise increments by 1.
  - In NS_G and EW_G it saturates at `MAX_GREEN-1`.
- **Demand latches `ns_dem`, `ew_dem`:**
  - Set on any edge where the request is high and the state is not that approach's green.
  - Cleared on the edge that enters that green. Clear wins over a simultaneous set.
- **Pedestrian latch `ped_dem`:** set on `ped_req`=1; cleared on entering PED. Clear wins.
- **Green exit from X_G:** requires the opposing latch to be set, and either:
  - counter ≥ `MIN_GREEN-1` and own request low (gap-out), or
  - counter ≥ `MAX_GREEN-1` (max-out).
- **Rest:** with no opposing demand, the arbiter rests in the current green indefinitely.
- **Timed states:**
  - NS_Y→AR1 and EW_Y→AR2 at counter = `YELLOW_TIME-1`.
  - AR1→EW_G at counter = `ALLRED_TIME-1`.
  - AR2→PED if `ped_dem` is set, else AR2→NS_G.
  - PED→NS_G at counter = `PED_TIME-1`.
- **Reset (asynchronous):** state NS_G, counter 0, all latches 0. Outputs immediately: NS_Green=1, EW_Red=1, all other lamps 0, walk=0, phase=0.

## Timing
- Lamps, `walk` and `phase` are a combinational decode of the state register. They change in the same cycle as the state edge, with no extra latency.
- A request sampled at edge k is visible in its latch after edge k. The earliest resulting green exit is edge k+1.
- Yellow lasts exactly `YELLOW_TIME` cycles, all-red `ALLRED_TIME`, walk `PED_TIME`.
- Green lasts between `MIN_GREEN` and `MAX_GREEN` cycles whenever the opposing approach is waiting.
- A `rst_n` assertion mid-phase (for example during EW_Y) forces NS_G outputs asynchronously. Deassertion takes effect synchronously at the next rising edge.

## Configuration
- `TLC_PED_EN` defined: `ped_dem` latch and PED state are present. Pedestrian service is inserted after AR2.
- `TLC_PED_EN` undefined:
  - `ped_req` is ignored and `walk` is tied 0.
  - AR2 always goes to NS_G, and PED is unreachable.
  - The `phase` value 6 never appears.

## Test plan
Parameters for all scenarios: MIN_GREEN=4, MAX_GREEN=8, YELLOW_TIME=2, ALLRED_TIME=1, PED_TIME=3.
- **Idle rest:** reset, no requests for 50 cycles → phase=0 throughout, NS_Green=1, EW_Red=1.
- **Gap-out:** ew_req one-cycle pulse at edge 10, ns_req low → NS_Y at edge 11, AR1 at 13, EW_G at 14.
- **Max-out:** ns_req held high, ew_req pulsed at edge 1 → NS_G is held 8 cycles (exit at counter 7), then NS_Y for 2 cycles, AR1 for 1 cycle, EW_G.
- **Pedestrian (macro on):**
  - ped_req pulsed while in EW_G, ns_req pulsed → sequence EW_Y(2), AR2(1), PED(3) with walk=1 and both approaches red, then NS_G.
  - Same stimulus with the macro off → PED is skipped.
- **Async reset:** rst_n driven low mid-EW_Y between clock edges → outputs switch to NS_Green=1, EW_Red=1, phase=0 before the next edge. Latches are 0 after release.
- **Simultaneous set/clear:** ns_req high on the edge entering NS_G → ns_dem=0 afterward. No spurious re-service occurs after the next EW cycle.
